uart_cmd_seq: RTL and testbench
===============================

UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload/response width in bits; multiple of 4, range 8..64.
REQ-002 SHALL have parameter N_CH, default 4, meaning number of dispatch channels, range 1..8.
REQ-003 SHALL have parameter TIMEOUT, default 5000000, meaning cycles to wait for channel completion (100 ms at 50 MHz).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_rch  in  8  received ASCII byte, valid when rx_rcv toggles.
REQ-007 SHALL have port rx_rcv  in  1  toggles once per received byte.
REQ-008 SHALL have port tx_tch  out  8  byte to transmit.
REQ-009 SHALL have port tx_cs  out  1  transmit request, held until tx_busy seen high.
REQ-010 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port ch_cs  out  N_CH  one-hot channel request.
REQ-012 SHALL have port ch_wdata  out  DATA_W  accumulated hex payload presented to the selected channel.
REQ-013 SHALL have port ch_ready  in  N_CH  per-channel completion; a toggle signals done.
REQ-014 SHALL have port ch_rdata  in  N_CH*DATA_W  channel k result in bits [k*DATA_W +: DATA_W].
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, DISPATCH, SEND, SENDING, SENDED.
REQ-017 SHALL sample rx_rcv into rx_rcv_old every cycle; a byte is accepted only when rx_rcv differs from rx_rcv_old while in IDLE. Toggles in any other state are discarded.
REQ-018 On accepting '$' (0x24), SHALL clear cmd and data, then echo '$'.
REQ-019 On accepting any byte other than '$' or '+', SHALL echo it; if cmd==0, cmd<=byte; otherwise data<={data[DATA_W-5:0], hex(byte)}.
REQ-020 hex() SHALL map 0-9, a-f and A-F to 0..15, and every other byte to 0. Digits beyond DATA_W/4 SHALL shift out at the MSB end.
REQ-021 On '+' with cmd in 'A'..'A'+N_CH-1: SHALL set ch_cs[cmd-'A'], drive ch_wdata=data, save ch_ready[k], load the timeout counter with TIMEOUT, and enter DISPATCH on the next cycle.
REQ-022 On '+' with any other cmd, including 0: SHALL send "ERR" and leave cmd/data unchanged.
REQ-023 In DISPATCH, a ch_ready[k] change SHALL clear ch_cs, latch ch_rdata slice k, and queue '+' followed by DATA_W/4 lowercase hex digits, MSB first.
REQ-024 In DISPATCH, if the counter reaches 0 before a toggle, SHALL clear ch_cs and send "TMO"; a toggle in the same cycle as expiry SHALL win.
REQ-025 SEND SHALL work as follows: count==0 -> IDLE; otherwise, when tx_busy==0, tx_tch<=buf[7:0], shift buf right 8, decrement count, tx_cs<=1, go to SENDING. SENDING: tx_busy==1 -> tx_cs<=0, go to SENDED. SENDED: tx_busy==0 -> SEND.
REQ-026 The send buffer SHALL be (1+DATA_W/4) bytes; the count SHALL be $clog2 of that plus 1 bits wide.
REQ-027 Channel and echo latency: the first tx_cs edge SHALL occur no earlier than 2 cycles after the triggering event.
REQ-028 Only one ch_cs bit SHALL ever be high at a time.

Reset
REQ-029 Reset SHALL force state=IDLE, tx_cs=0, tx_tch=0, ch_cs=0, ch_wdata=0, busy=0, cmd=0, data=0, count=0, and rx_rcv_old=rx_rcv.
REQ-030 Reset during DISPATCH or SEND SHALL abandon the operation immediately; ch_cs SHALL drop asynchronously.

Structure
REQ-031 A shared package SHALL hold state encodings, ASCII constants ('$', '+', 'A', "ERR", "TMO"), and the hex/ASCII conversion functions.
REQ-032 A sub-module, hex_resp_buf (parallel load, byte shift-out, count), SHALL implement the send buffer.

Verification
REQ-033 Bench SHALL check: bytes "$A1234+" with ch_rdata0=0xDEADBEEF toggled 10 cycles later -> echo "$A1234", ch_cs=0001, ch_wdata=0x00001234, response "+deadbeef".
REQ-034 Bench SHALL check: "$Z+" -> echo "$Z", then "ERR"; ch_cs stays 0.
REQ-035 Bench SHALL check: TIMEOUT=100, "$B+" with no ready toggle -> ch_cs=0010 for 100 cycles, then "TMO".
REQ-036 Bench SHALL check: "$C123456789+" (DATA_W=32) -> ch_wdata=0x23456789; "$Cxg+" -> ch_wdata=0.
REQ-037 Bench SHALL check: an rx_rcv toggle while SENDING is discarded (no extra echo); reset asserted mid-DISPATCH -> ch_cs=0 and busy=0 immediately.
REQ-038 Bench SHALL check: N_CH=8, DATA_W=16, "$H+" with ch_rdata7=0x00ab -> response "+00ab".

Source files
------------

// File: rtl/uart_cmd_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_cmd_seq_pkg                                           |
// | Description : Shared state encoding, ASCII constants and hex/ASCII       |
// |               conversion helpers for the UART command sequencer.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_cmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPATCH = 3'd1,
    ST_SEND     = 3'd2,
    ST_SENDING  = 3'd3,
    ST_SENDED   = 3'd4
  } state_t;

  localparam logic [7:0]  ASCII_DOLLAR = 8'h24;      // '$'
  localparam logic [7:0]  ASCII_PLUS   = 8'h2B;      // '+'
  localparam logic [7:0]  ASCII_A      = 8'h41;      // 'A'
  localparam logic [23:0] STR_ERR      = 24'h455252; // "ERR"
  localparam logic [23:0] STR_TMO      = 24'h544D4F; // "TMO"

  // ASCII hex digit to nibble; anything that is not a hex digit reads as 0
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [3:0] v;
    v = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)      v = 4'(c - 8'h30);
    else if (c >= 8'h61 && c <= 8'h66) v = 4'(c - 8'h57);
    else if (c >= 8'h41 && c <= 8'h46) v = 4'(c - 8'h37);
    return v;
  endfunction

  // Nibble to lowercase ASCII hex digit
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // The send buffer shifts out LSB byte first, so the first character of a
  // string literal has to sit in the lowest byte.
  function automatic logic [23:0] str_tx_order(input logic [23:0] s);
    return {s[7:0], s[15:8], s[23:16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_seq_hex_resp_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_resp_buf                                               |
// | Description : Transmit buffer: parallel load of up to N_BYTES bytes with |
// |               a byte count, shifted out one byte at a time LSB first.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hex_resp_buf #(
  parameter int N_BYTES = 9,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [N_BYTES*8-1:0] load_data,
  input  logic [CNT_W-1:0]     load_count,
  input  logic                 shift,
  output logic [7:0]           head,
  output logic [CNT_W-1:0]     count
);

  logic [N_BYTES*8-1:0] shreg;

  // Load a whole message, or drop the byte just handed to the transmitter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      count <= '0;
    end else if (load) begin
      shreg <= load_data;
      count <= load_count;
    end else if (shift && (count != '0)) begin
      shreg <= shreg >> 8;
      count <= count - CNT_W'(1);
    end
  end

  assign head = shreg[7:0];

endmodule
`default_nettype wire

// File: rtl/uart_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_cmd_seq                                               |
// | Description : ASCII command sequencer. Bytes from a UART receiver build  |
// |               a command letter plus hex payload; '+' dispatches it to a  |
// |               channel and the channel result is returned as hex text.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_cmd_seq
  import uart_cmd_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 5000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_rch,
  input  logic                   rx_rcv,
  output logic [7:0]             tx_tch,
  output logic                   tx_cs,
  input  logic                   tx_busy,
  output logic [N_CH-1:0]        ch_cs,
  output logic [DATA_W-1:0]      ch_wdata,
  input  logic [N_CH-1:0]        ch_ready,
  input  logic [N_CH*DATA_W-1:0] ch_rdata,
  output logic                   busy
);

  localparam int DIGITS  = DATA_W / 4;
  localparam int N_BYTES = 1 + DIGITS;
  localparam int BUF_W   = N_BYTES * 8;
  localparam int CNT_W   = $clog2(N_BYTES) + 1;
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state;
  logic              rx_rcv_old;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  ch_idx;
  logic              ready_old;
  logic [TMR_W-1:0]  timer;

  logic              rx_evt;
  logic              cmd_ok;
  logic [IDX_W-1:0]  cmd_idx;
  logic [DATA_W-1:0] rdata_sel;
  logic              ready_toggled;
  logic              expired;
  logic [BUF_W-1:0]  resp_bytes;

  logic              load;
  logic [BUF_W-1:0]  load_data;
  logic [CNT_W-1:0]  load_count;
  logic              shift;
  logic [7:0]        head;
  logic [CNT_W-1:0]  count;

  assign rx_evt        = (state == ST_IDLE) && (rx_rcv != rx_rcv_old);
  assign cmd_ok        = (cmd >= ASCII_A) && (cmd < (ASCII_A + 8'(N_CH)));
  assign cmd_idx       = IDX_W'(cmd - ASCII_A);
  assign rdata_sel     = ch_rdata[ch_idx*DATA_W +: DATA_W];
  assign ready_toggled = (ch_ready[ch_idx] != ready_old);
  assign expired       = (timer <= TMR_W'(1));
  assign busy          = (state != ST_IDLE);

  // Result message: '+' first, then the channel result MSB nibble first
  assign resp_bytes[7:0] = ASCII_PLUS;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign resp_bytes[8*(i+1) +: 8] = hex_char(rdata_sel[DATA_W-1-4*i -: 4]);
  end

  // Pick what, if anything, goes into the transmit buffer this cycle
  always_comb begin
    load       = 1'b0;
    load_data  = '0;
    load_count = '0;
    case (state)
      ST_IDLE: begin
        if (rx_evt) begin
          if (rx_rch == ASCII_PLUS) begin
            if (!cmd_ok) begin
              load       = 1'b1;
              load_data  = BUF_W'(str_tx_order(STR_ERR));
              load_count = CNT_W'(3);
            end
          end else begin
            load       = 1'b1;
            load_data  = BUF_W'(rx_rch);
            load_count = CNT_W'(1);
          end
        end
      end
      ST_DISPATCH: begin
        if (ready_toggled) begin
          load       = 1'b1;
          load_data  = resp_bytes;
          load_count = CNT_W'(N_BYTES);
        end else if (expired) begin
          load       = 1'b1;
          load_data  = BUF_W'(str_tx_order(STR_TMO));
          load_count = CNT_W'(3);
        end
      end
      default: ;
    endcase
  end

  assign shift = (state == ST_SEND) && (count != '0) && !tx_busy;

  hex_resp_buf #(
    .N_BYTES (N_BYTES),
    .CNT_W   (CNT_W)
  ) u_resp_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .shift      (shift),
    .head       (head),
    .count      (count)
  );

  // Command parsing, channel dispatch and transmit handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rx_rcv_old <= rx_rcv;
      cmd        <= '0;
      data       <= '0;
      ch_idx     <= '0;
      ready_old  <= 1'b0;
      timer      <= '0;
      tx_cs      <= 1'b0;
      tx_tch     <= '0;
      ch_cs      <= '0;
      ch_wdata   <= '0;
    end else begin
      rx_rcv_old <= rx_rcv;
      case (state)
        ST_IDLE: begin
          if (rx_evt) begin
            if (rx_rch == ASCII_DOLLAR) begin
              cmd   <= '0;
              data  <= '0;
              state <= ST_SEND;
            end else if (rx_rch == ASCII_PLUS) begin
              if (cmd_ok) begin
                ch_cs     <= N_CH'(1) << cmd_idx;
                ch_wdata  <= data;
                ch_idx    <= cmd_idx;
                ready_old <= ch_ready[cmd_idx];
                timer     <= TMR_W'(TIMEOUT);
                state     <= ST_DISPATCH;
              end else begin
                state <= ST_SEND;
              end
            end else begin
              if (cmd == '0) cmd <= rx_rch;
              else           data <= {data[DATA_W-5:0], hex_val(rx_rch)};
              state <= ST_SEND;
            end
          end
        end
        ST_DISPATCH: begin
          // A completion in the expiry cycle takes priority over the timeout
          if (ready_toggled || expired) begin
            ch_cs <= '0;
            state <= ST_SEND;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_SEND: begin
          if (count == '0) begin
            state <= ST_IDLE;
          end else if (!tx_busy) begin
            tx_tch <= head;
            tx_cs  <= 1'b1;
            state  <= ST_SENDING;
          end
        end
        ST_SENDING: begin
          if (tx_busy) begin
            tx_cs <= 1'b0;
            state <= ST_SENDED;
          end
        end
        ST_SENDED: begin
          if (!tx_busy) state <= ST_SEND;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_cmd_seq                                            |
// | Description : Scoreboard bench for uart_cmd_seq. Two instances: a 32-bit |
// |               4-channel one and a 16-bit 8-channel one.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_cmd_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: DATA_W=32, N_CH=4
  logic [7:0]   rx_rch_a, tx_tch_a;
  logic         rx_rcv_a, tx_cs_a, tx_busy_a, busy_a;
  logic [3:0]   ch_cs_a, ch_ready_a;
  logic [31:0]  ch_wdata_a;
  logic [127:0] ch_rdata_a;
  // instance B: DATA_W=16, N_CH=8
  logic [7:0]   rx_rch_b, tx_tch_b;
  logic         rx_rcv_b, tx_cs_b, tx_busy_b, busy_b;
  logic [7:0]   ch_cs_b, ch_ready_b;
  logic [15:0]  ch_wdata_b;
  logic [127:0] ch_rdata_b;

  uart_cmd_seq #(.DATA_W(32), .N_CH(4), .TIMEOUT(100)) dut_a (
    .clk(clk), .reset(reset), .rx_rch(rx_rch_a), .rx_rcv(rx_rcv_a),
    .tx_tch(tx_tch_a), .tx_cs(tx_cs_a), .tx_busy(tx_busy_a),
    .ch_cs(ch_cs_a), .ch_wdata(ch_wdata_a), .ch_ready(ch_ready_a),
    .ch_rdata(ch_rdata_a), .busy(busy_a));

  uart_cmd_seq #(.DATA_W(16), .N_CH(8), .TIMEOUT(100)) dut_b (
    .clk(clk), .reset(reset), .rx_rch(rx_rch_b), .rx_rcv(rx_rcv_b),
    .tx_tch(tx_tch_b), .tx_cs(tx_cs_b), .tx_busy(tx_busy_b),
    .ch_cs(ch_cs_b), .ch_wdata(ch_wdata_b), .ch_ready(ch_ready_b),
    .ch_rdata(ch_rdata_b), .busy(busy_b));

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  // reference model state: command letter and accumulated payload per instance
  logic [7:0]  m_cmd[2];
  logic [63:0] m_data[2];

  function automatic int dw(input int d);  return (d == 0) ? 32 : 16; endfunction
  function automatic int nch(input int d); return (d == 0) ? 4 : 8;   endfunction
  function automatic logic [63:0] mask(input int d);
    return (64'h1 << dw(d)) - 64'h1;
  endfunction

  function automatic logic [3:0] ref_hex(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 4'(c - "0");
    if (c >= "a" && c <= "f") return 4'(c - "a" + 10);
    if (c >= "A" && c <= "F") return 4'(c - "A" + 10);
    return 4'h0;
  endfunction

  function automatic logic        busy_of(input int d);  return (d == 0) ? busy_a : busy_b; endfunction
  function automatic logic        tx_cs_of(input int d); return (d == 0) ? tx_cs_a : tx_cs_b; endfunction
  function automatic logic [7:0]  ch_cs_of(input int d); return (d == 0) ? {4'h0, ch_cs_a} : ch_cs_b; endfunction
  function automatic logic [31:0] wdata_of(input int d); return (d == 0) ? ch_wdata_a : {16'h0, ch_wdata_b}; endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [7:0] c);
    if (d == 0) exp_a.push_back(c);
    else        exp_b.push_back(c);
  endtask

  // monitor side of the scoreboard: every transmitted byte must be the oldest expected one
  task automatic check_tx(input int d, input logic [7:0] got);
    logic [7:0] e;
    checks++;
    if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
      failures++;
      $display("FAIL tx_unexpected[%0d]: got %02h, required no byte", d, got);
    end else begin
      e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL tx_byte[%0d]: got %02h, required %02h (t=%0t)", d, got, e, $time);
      end
    end
  endtask

  // UART transmitter models: accept a byte when tx_cs is seen, stay busy a few cycles
  initial begin : tx_model_a
    tx_busy_a = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_cs_a && !tx_busy_a) begin
        check_tx(0, tx_tch_a);
        tx_busy_a = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        tx_busy_a = 1'b0;
      end
    end
  end

  initial begin : tx_model_b
    tx_busy_b = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_cs_b && !tx_busy_b) begin
        check_tx(1, tx_tch_b);
        tx_busy_b = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        tx_busy_b = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy_of(d) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy_of(d)) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout[%0d]: got busy=1, required busy=0", d);
    end
  endtask

  task automatic drive_rx(input int d, input logic [7:0] c);
    if (d == 0) begin rx_rch_a = c; rx_rcv_a = ~rx_rcv_a; end
    else        begin rx_rch_b = c; rx_rcv_b = ~rx_rcv_b; end
  endtask

  // stimulus side: deliver a byte and push what the protocol says must come back
  task automatic send_byte(input int d, input logic [7:0] c, output bit disp, output int k);
    disp = 1'b0;
    k = 0;
    wait_idle(d);
    @(negedge clk);
    drive_rx(d, c);
    if (c == "$") begin
      m_cmd[d] = 8'h0;
      m_data[d] = 64'h0;
      push(d, c);
    end else if (c == "+") begin
      if (m_cmd[d] >= "A" && int'(m_cmd[d]) < int'("A") + nch(d)) begin
        disp = 1'b1;
        k = int'(m_cmd[d]) - int'("A");
      end else begin
        push(d, "E"); push(d, "R"); push(d, "R");
      end
    end else begin
      push(d, c);
      if (m_cmd[d] == 8'h0) m_cmd[d] = c;
      else m_data[d] = ((m_data[d] << 4) | 64'(ref_hex(c))) & mask(d);
    end
    @(negedge clk);
    check("busy_after_rx", busy_of(d), 1);
    check("tx_cs_latency", tx_cs_of(d), 0);
    if (disp) begin
      check("ch_cs_dispatch", ch_cs_of(d), 64'h1 << k);
      check("ch_wdata", wdata_of(d), m_data[d]);
    end else begin
      check("ch_cs_quiet", ch_cs_of(d), 0);
    end
  endtask

  task automatic send_str(input int d, input string s, output bit disp, output int k);
    bit dd;
    int kk;
    disp = 1'b0;
    k = 0;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(d, s[i], dd, kk);
      disp = dd;
      k = kk;
    end
  endtask

  task automatic respond(input int d, input int k, input logic [31:0] val, input int dly);
    logic [31:0] v;
    v = (d == 0) ? val : (val & 32'h0000ffff);
    repeat (dly) @(negedge clk);
    check("ch_cs_held", ch_cs_of(d), 64'h1 << k);
    push(d, "+");
    for (int i = dw(d) / 4 - 1; i >= 0; i--) begin
      logic [3:0] n;
      n = 4'(v >> (4 * i));
      push(d, (n < 4'd10) ? 8'("0" + n) : 8'("a" + n - 10));
    end
    if (d == 0) begin ch_rdata_a[k*32 +: 32] = v;       ch_ready_a[k] = ~ch_ready_a[k]; end
    else        begin ch_rdata_b[k*16 +: 16] = v[15:0]; ch_ready_b[k] = ~ch_ready_b[k]; end
    @(negedge clk);
    check("ch_cs_clear", ch_cs_of(d), 0);
  endtask

  task automatic expect_timeout(input int d);
    int cnt = 0;
    push(d, "T"); push(d, "M"); push(d, "O");
    while (ch_cs_of(d) != 8'h0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_cycles", cnt, 100);
  endtask

  task automatic random_cmds(input int d, input int iters);
    string pool = "0123456789abcdefABCDEFxg";
    bit disp;
    int k;
    for (int it = 0; it < iters; it++) begin
      send_byte(d, "$", disp, k);
      if ($urandom_range(0, 9) != 0)
        send_byte(d, 8'("A" + $urandom_range(0, nch(d))), disp, k);
      for (int j = 0; j < int'($urandom_range(0, 10)); j++)
        send_byte(d, pool[$urandom_range(0, pool.len() - 1)], disp, k);
      send_byte(d, "+", disp, k);
      if (disp) begin
        if ($urandom_range(0, 5) == 0) expect_timeout(d);
        else respond(d, k, $urandom, $urandom_range(0, 30));
      end
      wait_idle(d);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit disp;
    int k;
    int n;
    rx_rch_a = 8'h0; rx_rcv_a = 1'b0; ch_ready_a = '0; ch_rdata_a = '0;
    rx_rch_b = 8'h0; rx_rcv_b = 1'b0; ch_ready_b = '0; ch_rdata_b = '0;
    for (int d = 0; d < 2; d++) begin m_cmd[d] = 8'h0; m_data[d] = 64'h0; end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_cs", tx_cs_a, 0);
    check("rst_tx_tch", tx_tch_a, 0);
    check("rst_ch_cs", ch_cs_a, 0);
    check("rst_ch_wdata", ch_wdata_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic dispatch with delayed completion
    send_str(0, "$A1234+", disp, k);
    check("wdata_1234", ch_wdata_a, 32'h00001234);
    check("ch_cs_0001", ch_cs_a, 4'b0001);
    respond(0, 0, 32'hDEADBEEF, 10);
    wait_idle(0);

    // unknown command letter
    send_str(0, "$Z+", disp, k);
    wait_idle(0);
    check("err_ch_cs", ch_cs_a, 0);

    // no completion -> timeout
    send_str(0, "$B+", disp, k);
    check("ch_cs_0010", ch_cs_a, 4'b0010);
    expect_timeout(0);
    wait_idle(0);

    // payload overflow and non-hex digits
    send_str(0, "$C123456789+", disp, k);
    check("wdata_overflow", ch_wdata_a, 32'h23456789);
    respond(0, k, $urandom, 3);
    send_str(0, "$Cxg+", disp, k);
    check("wdata_nonhex", ch_wdata_a, 32'h0);
    respond(0, k, $urandom, 0);

    // a byte arriving while the echo is being transmitted is dropped
    send_str(0, "$A1", disp, k);
    n = 0;
    while (!tx_cs_a && n < 100) begin @(negedge clk); n++; end
    check("tx_cs_seen", tx_cs_a, 1);
    drive_rx(0, "7");
    send_str(0, "2+", disp, k);
    check("wdata_discard", ch_wdata_a, 32'h12);
    respond(0, k, 32'h0badf00d, 4);
    wait_idle(0);

    // reset in the middle of a dispatch
    send_str(0, "$D5+", disp, k);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_ch_cs", ch_cs_a, 0);
    check("rst_mid_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin m_cmd[d] = 8'h0; m_data[d] = 64'h0; end
    @(negedge clk);

    // 8-channel, 16-bit instance on the last channel
    send_str(1, "$H+", disp, k);
    check("ch_cs_b_h", ch_cs_b, 8'h80);
    respond(1, 7, 32'h000000ab, 5);
    wait_idle(1);

    random_cmds(0, 25);
    random_cmds(1, 15);

    wait_idle(0);
    wait_idle(1);
    repeat (10) @(negedge clk);
    check("exp_left_a", exp_a.size(), 0);
    check("exp_left_b", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
